raid_rebuild_ctrl: RTL and testbench
====================================

RAID_REBUILD_CTRL -- requirements
Module: raid_rebuild_ctrl

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 4: blocks per rebuild pass (addresses 0..NUM_BLOCKS-1, max 256).
REQ-002 SHALL have parameter TIMEOUT, default 15: max wait cycles for rd_data_valid or wr_done.
REQ-003 SHALL have port clk  in  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  pulse; request a rebuild pass.
REQ-006 SHALL have port disk_stat  in  3  disk health, 1=healthy; legal values 3'b110, 3'b101, 3'b011.
REQ-007 SHALL have port abort  in  1  cancel the pass in progress.
REQ-008 SHALL have port rd_data_valid  in  1  read path returned the block for the current address.
REQ-009 SHALL have port wr_done  in  1  write path finished the current reconstructed block.
REQ-010 SHALL have port rd_start  out  1  one-cycle pulse; read path loads disk_stat_out and begins at address 0.
REQ-011 SHALL have port rd_next  out  1  one-cycle pulse; read path advances to the next address.
REQ-012 SHALL have port disk_stat_out  out  3  disk_stat latched at accepted start.
REQ-013 SHALL have port cur_addr  out  8  address currently being rebuilt.
REQ-014 SHALL have ports busy, done, error  out  1 each: pass active; one-cycle completion pulse; sticky error flag.
REQ-015 SHALL have port err_code  out  2  00 none, 01 illegal disk_stat, 10 timeout, 11 aborted.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_DATA, WAIT_WR, NEXT, DONE.
REQ-017 SHALL, in IDLE, on start with legal disk_stat: latch disk_stat_out, set cur_addr=0, clear error/err_code, go to ISSUE.
REQ-018 SHALL, in IDLE, on start with illegal disk_stat: stay IDLE, set error=1, err_code=01 on the next cycle.
REQ-019 SHALL assert rd_start for exactly the one cycle spent in ISSUE, then enter WAIT_DATA.
REQ-020 SHALL move WAIT_DATA->WAIT_WR on rd_data_valid; a wr_done in WAIT_DATA is ignored.
REQ-021 SHALL, in WAIT_WR on wr_done: go to DONE if cur_addr==NUM_BLOCKS-1, else go to NEXT.
REQ-022 SHALL, in NEXT (one cycle), assert rd_next, increment cur_addr by 1, then enter WAIT_DATA.
REQ-023 SHALL assert done for the one cycle spent in DONE, then return to IDLE with cur_addr held.
REQ-024 SHALL keep busy=1 in every state except IDLE.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL run a wait counter cleared on entry to WAIT_DATA/WAIT_WR; reaching TIMEOUT cycles without the awaited event -> IDLE, error=1, err_code=10.
REQ-027 SHALL, on abort while busy: go to IDLE next cycle, error=1, err_code=11; abort takes priority over every other input except reset.
REQ-028 SHALL treat abort in IDLE as no-op.
REQ-029 SHALL hold error/err_code until the next accepted start or reset.
REQ-030 SHALL let rd_data_valid and timeout expiry in the same cycle resolve as the event (no error).
REQ-031 SHALL drive all outputs from flops (no combinational input-to-output path).

Reset
REQ-032 SHALL, while reset=1 at a clk edge: state=IDLE, all outputs 0, wait counter 0.
REQ-033 SHALL on reset mid-pass abandon the pass silently (no done, no error).

Structure
REQ-034 SHALL take state enum, err_code constants and legal disk_stat encodings from shared package raid_pkg.
REQ-035 SHALL be a single module; no sub-module.

Verification
REQ-036 SHALL cover: start, disk_stat=110, rd_data_valid and wr_done 2 cycles after each request -> rd_start once, rd_next 3 times, cur_addr 0..3, done one cycle after 4th wr_done.
REQ-037 SHALL cover: start with disk_stat=111 -> no rd_start, busy=0, error=1, err_code=01.
REQ-038 SHALL cover: no rd_data_valid after rd_start -> after 15 wait cycles IDLE, error=1, err_code=10.
REQ-039 SHALL cover: abort during WAIT_WR at cur_addr=2 -> IDLE next cycle, err_code=11, no done; a subsequent legal start clears error.
REQ-040 SHALL cover: start asserted while busy, plus wr_done during WAIT_DATA -> both ignored, sequence unchanged.
REQ-041 SHALL cover: reset asserted at cur_addr=1 -> all outputs 0 next cycle, no done/error.

Source files
------------

// File: rtl/raid_pkg.sv
// Shared types and constants for the RAID rebuild controller:
// controller states, error codes and the legal disk health encodings.
package raid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_WAIT_WR,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DISK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  // Exactly one disk may be failed; these are the only rebuildable patterns.
  localparam logic [2:0] DS_LEGAL_A = 3'b110;
  localparam logic [2:0] DS_LEGAL_B = 3'b101;
  localparam logic [2:0] DS_LEGAL_C = 3'b011;

  function automatic logic disk_stat_legal(input logic [2:0] ds);
    return (ds == DS_LEGAL_A) || (ds == DS_LEGAL_B) || (ds == DS_LEGAL_C);
  endfunction

endpackage

// File: rtl/raid_rebuild_ctrl.sv
// Sequences one rebuild pass over NUM_BLOCKS addresses: read a block, wait for
// the reconstructed write, advance. Every output is a flop.
module raid_rebuild_ctrl
  import raid_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] disk_stat,
  input  logic       abort,
  input  logic       rd_data_valid,
  input  logic       wr_done,
  output logic       rd_start,
  output logic       rd_next,
  output logic [2:0] disk_stat_out,
  output logic [7:0] cur_addr,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int         CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [7:0] LAST_ADDR = 8'(NUM_BLOCKS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic [CW-1:0] r_wait_cnt;

  logic w_last;
  logic w_timeout;

  assign w_last    = (cur_addr == LAST_ADDR);
  // True in the TIMEOUT-th cycle spent waiting; the awaited event still wins.
  assign w_timeout = (r_wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      rd_start      <= 1'b0;
      rd_next       <= 1'b0;
      disk_stat_out <= '0;
      cur_addr      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      rd_start <= 1'b0;
      rd_next  <= 1'b0;
      done     <= 1'b0;

      if (busy && abort) begin
        r_state    <= S_IDLE;
        r_wait_cnt <= '0;
        busy       <= 1'b0;
        error      <= 1'b1;
        err_code   <= ERR_ABORT;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (disk_stat_legal(disk_stat)) begin
                r_state       <= S_ISSUE;
                disk_stat_out <= disk_stat;
                cur_addr      <= '0;
                error         <= 1'b0;
                err_code      <= ERR_NONE;
                busy          <= 1'b1;
                rd_start      <= 1'b1;
              end else begin
                error    <= 1'b1;
                err_code <= ERR_DISK;
              end
            end
          end

          S_ISSUE: begin
            r_state    <= S_WAIT_DATA;
            r_wait_cnt <= '0;
          end

          S_WAIT_DATA: begin
            if (rd_data_valid) begin
              r_state    <= S_WAIT_WR;
              r_wait_cnt <= '0;
            end else if (w_timeout) begin
              r_state    <= S_IDLE;
              r_wait_cnt <= '0;
              busy       <= 1'b0;
              error      <= 1'b1;
              err_code   <= ERR_TIMEOUT;
            end else begin
              r_wait_cnt <= r_wait_cnt + CW'(1);
            end
          end

          S_WAIT_WR: begin
            if (wr_done) begin
              r_wait_cnt <= '0;
              if (w_last) begin
                r_state <= S_DONE;
                done    <= 1'b1;
              end else begin
                r_state <= S_NEXT;
                rd_next <= 1'b1;
              end
            end else if (w_timeout) begin
              r_state    <= S_IDLE;
              r_wait_cnt <= '0;
              busy       <= 1'b0;
              error      <= 1'b1;
              err_code   <= ERR_TIMEOUT;
            end else begin
              r_wait_cnt <= r_wait_cnt + CW'(1);
            end
          end

          S_NEXT: begin
            r_state    <= S_WAIT_DATA;
            r_wait_cnt <= '0;
            cur_addr   <= cur_addr + 8'd1;
          end

          S_DONE: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end

          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_raid_rebuild_ctrl.sv
// Bench for raid_rebuild_ctrl: directed vector table, corner-case sequences and
// randomized traffic compared against a pass-level reference model.
module tb_raid_rebuild_ctrl;

  localparam int NB = 4;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic       rd_data_valid = 1'b0, wr_done = 1'b0;
  logic [2:0] disk_stat = 3'b000;
  logic       rd_start, rd_next, busy, done, error;
  logic [2:0] disk_stat_out;
  logic [7:0] cur_addr;
  logic [1:0] err_code;

  int vectors = 0;
  int miscompares = 0;

  raid_rebuild_ctrl #(.NUM_BLOCKS(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .disk_stat(disk_stat),
    .abort(abort), .rd_data_valid(rd_data_valid), .wr_done(wr_done),
    .rd_start(rd_start), .rd_next(rd_next), .disk_stat_out(disk_stat_out),
    .cur_addr(cur_addr), .busy(busy), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Reference model: pass bookkeeping in plain variables.
  bit       m_busy, m_rs, m_rn, m_done, m_err;
  bit [1:0] m_code;
  bit [2:0] m_dso;
  int       m_addr;
  int       m_wait_for;  // 0 nothing awaited, 1 read data, 2 write completion
  int       m_waited;

  function automatic bit legal_ds(input bit [2:0] d);
    return $countones(d) == 2;
  endfunction

  task automatic model_edge(input bit rs, st, input bit [2:0] ds, input bit ab, rv, wd);
    if (rs) begin
      m_busy = 0; m_rs = 0; m_rn = 0; m_done = 0; m_err = 0; m_code = 0;
      m_dso = 0; m_addr = 0; m_wait_for = 0; m_waited = 0;
    end else if (!m_busy) begin
      if (st && legal_ds(ds)) begin
        m_busy = 1; m_rs = 1; m_addr = 0; m_dso = ds; m_err = 0; m_code = 0;
        m_wait_for = 0;
      end else if (st) begin
        m_err = 1; m_code = 2'b01;
      end
    end else if (ab) begin
      m_busy = 0; m_rs = 0; m_rn = 0; m_done = 0; m_err = 1; m_code = 2'b11;
      m_wait_for = 0;
    end else if (m_rs || m_rn) begin
      if (m_rn) m_addr++;
      m_rs = 0; m_rn = 0; m_wait_for = 1; m_waited = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else begin
      if ((m_wait_for == 1 && rv) || (m_wait_for == 2 && wd)) begin
        if (m_wait_for == 1) begin
          m_wait_for = 2; m_waited = 0;
        end else begin
          m_wait_for = 0;
          if (m_addr == NB - 1) m_done = 1;
          else m_rn = 1;
        end
      end else if (m_waited == TO - 1) begin
        m_busy = 0; m_err = 1; m_code = 2'b10; m_wait_for = 0;
      end else begin
        m_waited++;
      end
    end
  endtask

  function automatic logic [17:0] pack(input logic b, rs, rn, dn, er,
                                       input logic [1:0] cd, input logic [7:0] ad,
                                       input logic [2:0] ds);
    return {b, rs, rn, dn, er, cd, ad, ds};
  endfunction

  function automatic logic [17:0] dut_vec();
    return pack(busy, rd_start, rd_next, done, error, err_code, cur_addr, disk_stat_out);
  endfunction

  function automatic logic [17:0] model_vec();
    return pack(m_busy, m_rs, m_rn, m_done, m_err, m_code, 8'(m_addr), m_dso);
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got busy/rs/rn/done/err/code/addr/dso=%h want %h",
               name, $time, act, exp);
    end
  endtask

  task automatic apply(input bit rs, st, input bit [2:0] ds, input bit ab, rv, wd);
    @(negedge clk);
    reset = rs; start = st; disk_stat = ds; abort = ab;
    rd_data_valid = rv; wr_done = wd;
    model_edge(rs, st, ds, ab, rv, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input bit rs, st, input bit [2:0] ds,
                      input bit ab, rv, wd);
    apply(rs, st, ds, ab, rv, wd);
    check(name, dut_vec(), model_vec());
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {17'd0, act}, {17'd0, exp});
  endtask

  typedef struct {
    bit        rs, st;
    bit [2:0]  ds;
    bit        ab, rv, wd;
    logic [17:0] exp;
  } vec_t;

  function automatic vec_t v(input bit rs, st, input bit [2:0] ds, input bit ab, rv, wd,
                             input logic [17:0] exp);
    vec_t r;
    r.rs = rs; r.st = st; r.ds = ds; r.ab = ab; r.rv = rv; r.wd = wd; r.exp = exp;
    return r;
  endfunction

  vec_t tbl[25];
  bit [2:0] legal_set[3] = '{3'b110, 3'b101, 3'b011};

  initial begin
    // Nominal 4-block pass, start+wr_done ignored mid-pass, then illegal start.
    tbl[0]  = v(1,0,0,0,0,0, pack(0,0,0,0,0,0,0,0));
    tbl[1]  = v(0,1,6,0,0,0, pack(1,1,0,0,0,0,0,6));
    tbl[2]  = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,0,6));
    tbl[3]  = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,0,6));
    tbl[4]  = v(0,0,0,0,1,0, pack(1,0,0,0,0,0,0,6));
    tbl[5]  = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,0,6));
    tbl[6]  = v(0,0,0,0,0,1, pack(1,0,1,0,0,0,0,6));
    tbl[7]  = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,1,6));
    tbl[8]  = v(0,1,5,0,0,1, pack(1,0,0,0,0,0,1,6));
    tbl[9]  = v(0,0,0,0,1,0, pack(1,0,0,0,0,0,1,6));
    tbl[10] = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,1,6));
    tbl[11] = v(0,0,0,0,0,1, pack(1,0,1,0,0,0,1,6));
    tbl[12] = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,2,6));
    tbl[13] = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,2,6));
    tbl[14] = v(0,0,0,0,1,0, pack(1,0,0,0,0,0,2,6));
    tbl[15] = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,2,6));
    tbl[16] = v(0,0,0,0,0,1, pack(1,0,1,0,0,0,2,6));
    tbl[17] = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,3,6));
    tbl[18] = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,3,6));
    tbl[19] = v(0,0,0,0,1,0, pack(1,0,0,0,0,0,3,6));
    tbl[20] = v(0,0,0,0,0,0, pack(1,0,0,0,0,0,3,6));
    tbl[21] = v(0,0,0,0,0,1, pack(1,0,0,1,0,0,3,6));
    tbl[22] = v(0,0,0,0,0,0, pack(0,0,0,0,0,0,3,6));
    tbl[23] = v(0,1,7,0,0,0, pack(0,0,0,0,1,1,3,6));
    tbl[24] = v(0,0,0,0,0,0, pack(0,0,0,0,1,1,3,6));

    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].rs, tbl[i].st, tbl[i].ds, tbl[i].ab, tbl[i].rv, tbl[i].wd);
      check($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // Timeout: no read data for TO cycles.
    step("to_reset", 1,0,0,0,0,0);
    step("to_start", 0,1,3'b110,0,0,0);
    for (int i = 0; i < TO; i++) step("to_wait", 0,0,0,0,0,0);
    check_bit("to_still_busy", busy, 1'b1);
    step("to_expire", 0,0,0,0,0,0);
    check("to_result", {14'd0, busy, error, err_code}, {14'd0, 1'b0, 1'b1, 2'b10});

    // Read data arriving in the final allowed cycle wins over the timeout.
    step("edge_start", 0,1,3'b101,0,0,0);
    for (int i = 0; i < TO; i++) step("edge_wait", 0,0,0,0,0,0);
    step("edge_rv", 0,0,0,0,1,0);
    check("edge_result", {14'd0, busy, error, err_code}, {14'd0, 1'b1, 1'b0, 2'b00});
    step("edge_wd", 0,0,0,0,0,1);
    check_bit("edge_rd_next", rd_next, 1'b1);

    // Abort in WAIT_WR at address 2, then a legal start clears the error.
    step("ab_reset", 1,0,0,0,0,0);
    step("ab_start", 0,1,3'b110,0,0,0);
    step("ab_issue", 0,0,0,0,0,0);
    for (int a = 0; a <= 2; a++) begin
      step("ab_rv", 0,0,0,0,1,0);
      if (a < 2) begin
        step("ab_wd", 0,0,0,0,0,1);
        step("ab_next", 0,0,0,0,0,0);
      end
    end
    step("ab_abort", 0,0,0,1,0,1);
    check("ab_result", {10'd0, busy, done, error, err_code, 3'd0} | {10'd0, 5'd0, 3'd0},
          {10'd0, 1'b0, 1'b0, 1'b1, 2'b11, 3'd0});
    check("ab_addr", {10'd0, cur_addr}, {10'd0, 8'd2});
    step("ab_restart", 0,1,3'b011,0,0,0);
    check("ab_cleared", {13'd0, busy, rd_start, error, err_code},
          {13'd0, 1'b1, 1'b1, 1'b0, 2'b00});

    // Reset mid-pass at address 1.
    step("rs_issue", 0,0,0,0,0,0);
    step("rs_rv", 0,0,0,0,1,0);
    step("rs_wd", 0,0,0,0,0,1);
    step("rs_next", 0,0,0,0,0,0);
    check("rs_addr1", {10'd0, cur_addr}, {10'd0, 8'd1});
    step("rs_reset", 1,0,0,0,0,0);
    check("rs_all_zero", dut_vec(), 18'd0);
    step("rs_after", 0,0,0,0,0,0);
    check("rs_quiet", dut_vec(), 18'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit       r_rs, r_st, r_ab, r_rv, r_wd;
      bit [2:0] r_ds;
      r_rs = ($urandom_range(0, 299) == 0);
      r_st = ($urandom_range(0, 5) == 0);
      r_ds = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                         : legal_set[$urandom_range(0, 2)];
      r_ab = ($urandom_range(0, 79) == 0);
      r_rv = ($urandom_range(0, 2) == 0);
      r_wd = ($urandom_range(0, 2) == 0);
      step("random", r_rs, r_st, r_ds, r_ab, r_rv, r_wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
